// File: rtl/comb_equiv_pkg.sv
// Shared types for the exhaustive equivalence sweeper: FSM state encoding.
// Optional build macro used by the sweeper: STOP_ON_FAIL_EN.
package comb_equiv_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/equiv_compare.sv
// Registered comparator for the sweeper: counts mismatching vectors and
// captures the first (lowest) failing vector of a sweep.
module equiv_compare #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              sample,
    input  logic [N_IN-1:0]   vec,
    input  logic [N_OUT-1:0]  dut_a,
    input  logic [N_OUT-1:0]  dut_b,
    output logic              mismatch,
    output logic [N_IN:0]     mismatch_cnt,
    output logic [N_IN-1:0]   first_fail_vec,
    output logic              first_fail_valid
);

    assign mismatch = (dut_a != dut_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_cnt     <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else if (clear) begin
            mismatch_cnt     <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else if (sample && mismatch) begin
            // Vectors are visited in ascending order, so the first capture is the lowest.
            mismatch_cnt <= mismatch_cnt + (N_IN+1)'(1);
            if (!first_fail_valid) begin
                first_fail_vec   <= vec;
                first_fail_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/comb_equiv_sweeper.sv
// Exhaustive equivalence sweeper: drives every N_IN-bit vector to two implementations,
// holds it HOLD cycles, then compares. Define STOP_ON_FAIL_EN to end at the first mismatch.
module comb_equiv_sweeper
    import comb_equiv_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 1,
    parameter int HOLD  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [N_IN-1:0]   vec_out,
    input  logic [N_OUT-1:0]  dut_a,
    input  logic [N_OUT-1:0]  dut_b,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     mismatch_cnt,
    output logic [N_IN-1:0]   first_fail_vec,
    output logic              first_fail_valid
);

    localparam int SW = (HOLD > 1) ? $clog2(HOLD) : 1;

    state_t         state, next_state;
    logic [N_IN-1:0] vec_q, vec_next;
    logic [SW-1:0]  settle, settle_next;
    logic           clear, sample, mismatch, stop_on_fail;

`ifdef STOP_ON_FAIL_EN
    assign stop_on_fail = 1'b1;
`else
    assign stop_on_fail = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            vec_q  <= '0;
            settle <= '0;
        end else begin
            state  <= next_state;
            vec_q  <= vec_next;
            settle <= settle_next;
        end
    end

    always_comb begin
        next_state  = state;
        vec_next    = vec_q;
        settle_next = settle;
        clear       = 1'b0;
        sample      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state  = DRIVE;
                    vec_next    = '0;
                    settle_next = '0;
                    clear       = 1'b1;
                end
            end
            DRIVE: begin
                if (settle == SW'(HOLD - 1)) next_state = SAMPLE;
                else                         settle_next = settle + SW'(1);
            end
            SAMPLE: begin
                sample      = 1'b1;
                settle_next = '0;
                // Vector is held at the last compared value when the sweep ends.
                if ((stop_on_fail && mismatch) || (&vec_q)) begin
                    next_state = DONE;
                end else begin
                    next_state = DRIVE;
                    vec_next   = vec_q + N_IN'(1);
                end
            end
            default: next_state = IDLE;
        endcase
    end

    equiv_compare #(.N_IN(N_IN), .N_OUT(N_OUT)) u_compare (
        .clk              (clk),
        .rst_n            (rst_n),
        .clear            (clear),
        .sample           (sample),
        .vec              (vec_q),
        .dut_a            (dut_a),
        .dut_b            (dut_b),
        .mismatch         (mismatch),
        .mismatch_cnt     (mismatch_cnt),
        .first_fail_vec   (first_fail_vec),
        .first_fail_valid (first_fail_valid)
    );

    assign vec_out = vec_q;
    assign busy    = (state == DRIVE) || (state == SAMPLE);
    assign done    = (state == DONE);
    assign pass    = done && (mismatch_cnt == '0);

endmodule

// File: tb/tb_comb_equiv_sweeper.sv
// Directed, table-driven bench for comb_equiv_sweeper (HOLD=1 and HOLD=3 instances).
module tb_comb_equiv_sweeper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start3 = 1'b0;
    logic [15:0] fault_mask = 16'h0000;

    logic [3:0] vec_out, vec_out3;
    logic [0:0] dut_a, dut_b, dut_a3, dut_b3;
    logic       busy, done, pass, busy3, done3, pass3;
    logic [4:0] mismatch_cnt, mismatch_cnt3;
    logic [3:0] first_fail_vec, first_fail_vec3;
    logic       first_fail_valid, first_fail_valid3;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Implementation A: parity. Implementation B: parity with injected faults.
    assign dut_a  = ^vec_out;
    assign dut_b  = (^vec_out) ^ fault_mask[vec_out];
    assign dut_a3 = ^vec_out3;
    assign dut_b3 = ^vec_out3;

    comb_equiv_sweeper #(.N_IN(4), .N_OUT(1), .HOLD(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_out(vec_out),
        .dut_a(dut_a), .dut_b(dut_b), .busy(busy), .done(done), .pass(pass),
        .mismatch_cnt(mismatch_cnt), .first_fail_vec(first_fail_vec),
        .first_fail_valid(first_fail_valid)
    );

    comb_equiv_sweeper #(.N_IN(4), .N_OUT(1), .HOLD(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .vec_out(vec_out3),
        .dut_a(dut_a3), .dut_b(dut_b3), .busy(busy3), .done(done3), .pass(pass3),
        .mismatch_cnt(mismatch_cnt3), .first_fail_vec(first_fail_vec3),
        .first_fail_valid(first_fail_valid3)
    );

    typedef struct {
        logic [15:0] mask;
        int          exp_cnt;
        logic [3:0]  exp_ffv;
        logic        exp_valid;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pulse (or hold) start on the HOLD=1 instance, count edges until done.
    task automatic run_sweep(input bit hold_start, output int edges, output bit step_ok);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        edges   = 0;
        step_ok = (vec_out == 4'd0) && busy;
        while (!done && edges < 200) begin
            @(negedge clk);
            edges++;
            if (!done && vec_out != 4'(edges / 2)) step_ok = 1'b0;
        end
    endtask

    initial begin
        int  edges;
        bit  step_ok;
        int  exp_edges;
        int  exp_cnt;
        logic [3:0] exp_vec;

        tbl[0] = '{16'h0000, 0,  4'h0, 1'b0};
        tbl[1] = '{16'h0840, 2,  4'h6, 1'b1};
        tbl[2] = '{16'h0001, 1,  4'h0, 1'b1};
        tbl[3] = '{16'h8000, 1,  4'hF, 1'b1};
        tbl[4] = '{16'h8001, 2,  4'h0, 1'b1};
        tbl[5] = '{16'hFFFF, 16, 4'h0, 1'b1};
        tbl[6] = '{16'h0228, 3,  4'h3, 1'b1};

        repeat (3) @(negedge clk);
        check("reset_vec_out", int'(vec_out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_pass", int'(pass), 0);
        check("reset_cnt", int'(mismatch_cnt), 0);
        check("reset_ffv", int'(first_fail_vec), 0);
        check("reset_ffvalid", int'(first_fail_valid), 0);
        check("reset_busy3", int'(busy3), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            fault_mask = tbl[i].mask;
`ifdef STOP_ON_FAIL_EN
            exp_edges = tbl[i].exp_valid ? (int'(tbl[i].exp_ffv) + 1) * 2 : 32;
            exp_cnt   = tbl[i].exp_valid ? 1 : 0;
            exp_vec   = tbl[i].exp_valid ? tbl[i].exp_ffv : 4'hF;
`else
            exp_edges = 32;
            exp_cnt   = tbl[i].exp_cnt;
            exp_vec   = 4'hF;
`endif
            run_sweep(1'b0, edges, step_ok);
            check($sformatf("t%0d_edges", i), edges, exp_edges);
            check($sformatf("t%0d_step", i), int'(step_ok), 1);
            check($sformatf("t%0d_busy", i), int'(busy), 0);
            check($sformatf("t%0d_vec_out", i), int'(vec_out), int'(exp_vec));
            check($sformatf("t%0d_cnt", i), int'(mismatch_cnt), exp_cnt);
            check($sformatf("t%0d_ffvalid", i), int'(first_fail_valid), int'(tbl[i].exp_valid));
            check($sformatf("t%0d_ffv", i), int'(first_fail_vec), int'(tbl[i].exp_ffv));
            check($sformatf("t%0d_pass", i), int'(pass), int'(exp_cnt == 0));
            repeat (3) @(negedge clk);
            check($sformatf("t%0d_done_held", i), int'(done), 1);
        end

        // Asynchronous reset while vector 5 is being driven.
        fault_mask = 16'h0000;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 0;
        while (vec_out != 4'd5 && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        check("rst_reached_vec5", int'(vec_out), 5);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_vec_out", int'(vec_out), 0);
        check("rst_async_busy", int'(busy), 0);
        check("rst_async_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_idle_busy", int'(busy), 0);
        check("rst_idle_done", int'(done), 0);
        check("rst_idle_vec", int'(vec_out), 0);

        // start held high: no restart mid-sweep, restart on the DONE edge.
        fault_mask = tbl[1].mask;
`ifdef STOP_ON_FAIL_EN
        exp_edges = 14;
        exp_cnt   = 1;
`else
        exp_edges = 32;
        exp_cnt   = 2;
`endif
        run_sweep(1'b1, edges, step_ok);
        check("held_edges", edges, exp_edges);
        check("held_step", int'(step_ok), 1);
        check("held_cnt", int'(mismatch_cnt), exp_cnt);
        @(negedge clk);
        check("held_restart_done", int'(done), 0);
        check("held_restart_busy", int'(busy), 1);
        check("held_restart_cnt", int'(mismatch_cnt), 0);
        check("held_restart_ffvalid", int'(first_fail_valid), 0);
        check("held_restart_vec", int'(vec_out), 0);
        edges = 0;
        while (!done && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        check("held_second_edges", edges, exp_edges);
        start = 1'b0;
        fault_mask = 16'h0000;

        // HOLD=3 instance: vector steps every 4 cycles, done 64 edges after start.
        @(negedge clk);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        edges   = 0;
        step_ok = busy3 && (vec_out3 == 4'd0);
        while (!done3 && edges < 300) begin
            @(negedge clk);
            edges++;
            if (!done3 && vec_out3 != 4'(edges / 4)) step_ok = 1'b0;
        end
        check("hold3_edges", edges, 64);
        check("hold3_step", int'(step_ok), 1);
        check("hold3_pass", int'(pass3), 1);
        check("hold3_cnt", int'(mismatch_cnt3), 0);
        check("hold3_vec_out", int'(vec_out3), 15);
        check("hold3_ffvalid", int'(first_fail_valid3), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
